// File: rtl/btn_event_pkg.sv
// rtl/btn_event_pkg.sv - shared types and constants for the key-event decoder
// Holds the key count, code width, the {press, code} event record and the
// decoder state enum used by btn_event.
package btn_event_pkg;

  localparam int KEY_COUNT  = 25;
  localparam int KEY_CODE_W = 5;
  localparam int EVT_W      = KEY_CODE_W + 1;

  typedef struct packed {
    logic                  press;
    logic [KEY_CODE_W-1:0] code;
  } evt_t;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    EMIT
  } state_t;

endpackage

// File: rtl/btn_event_evt_fifo.sv
// rtl/btn_event_evt_fifo.sv - synchronous event FIFO with registered occupancy
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   push, push_data    write request and data; ignored when full unless popping
//   pop                read request; ignored when empty
//   pop_data           head entry, forced to 0 when empty
//   full, empty        occupancy flags derived from the registered count
module evt_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/btn_event.sv
// rtl/btn_event.sv - debounced keypad press/release event decoder
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   btn[24:0]           raw key vector from the matrix scanner (bit 5*x+y)
//   evt_valid           event FIFO head is valid
//   evt_code[4:0]       key index of the head event (0 when empty)
//   evt_press           1 = press, 0 = release (0 when empty)
//   evt_ready           consumer pops the head event this cycle
//   key_state[24:0]     committed, debounced key vector
//   overflow            sticky flag: an event was dropped on a full FIFO
//   ovf_clr             clears overflow (a same-cycle drop wins)
module btn_event
  import btn_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEY_COUNT-1:0]  btn,
  output logic                  evt_valid,
  output logic [KEY_CODE_W-1:0] evt_code,
  output logic                  evt_press,
  input  logic                  evt_ready,
  output logic [KEY_COUNT-1:0]  key_state,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [KEY_COUNT-1:0] KEY_ONE = KEY_COUNT'(1);

  function automatic logic [KEY_CODE_W-1:0] lsb_index(input logic [KEY_COUNT-1:0] v);
    lsb_index = '0;
    // Scanning downward leaves the lowest set index as the final assignment.
    for (int i = KEY_COUNT - 1; i >= 0; i--) begin
      if (v[i]) begin
        lsb_index = KEY_CODE_W'(i);
      end
    end
  endfunction

  logic [KEY_COUNT-1:0]  samp;
  logic [CNT_W-1:0]      stab_cnt;
  logic [KEY_COUNT-1:0]  pending;
  logic [KEY_COUNT-1:0]  dir;
  logic [KEY_COUNT-1:0]  pending_clr;
  logic [KEY_CODE_W-1:0] lsb_code;
  logic                  settled;
  state_t                state;
  state_t                state_nxt;
  logic                  do_commit;
  logic                  do_emit;
  logic                  evt_push;
  evt_t                  push_evt;
  evt_t                  head_evt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  drop;

  // The counter compares the incoming sample against the held one, so it
  // restarts on the same edge that loads a new value into samp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp     <= '0;
      stab_cnt <= '0;
    end else begin
      samp <= btn;
      if (btn != samp) begin
        stab_cnt <= '0;
      end else if (stab_cnt != CNT_MAX) begin
        stab_cnt <= stab_cnt + CNT_ONE;
      end
    end
  end

  // >= rather than == so a vector that settled while busy still commits
  // once the machine is back in IDLE.
  assign settled     = (stab_cnt >= CNT_TRIG);
  assign lsb_code    = lsb_index(pending);
  assign pending_clr = pending & ~(KEY_ONE << lsb_code);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (settled && (samp != key_state)) state_nxt = COMMIT;
      COMMIT:  state_nxt = EMIT;
      EMIT:    if (pending_clr == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    do_commit = (state == COMMIT);
    do_emit   = (state == EMIT);
    // Guards the corner where btn reverted on the decision cycle and the
    // commit carries no change at all.
    evt_push  = do_emit && (pending != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_state <= '0;
      pending   <= '0;
      dir       <= '0;
    end else if (do_commit) begin
      pending   <= samp ^ key_state;
      key_state <= samp;
      dir       <= samp;
    end else if (do_emit) begin
      pending   <= pending_clr;
    end
  end

  assign push_evt.press = dir[lsb_code];
  assign push_evt.code  = lsb_code;

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (evt_push),
    .push_data (push_evt),
    .pop       (pop),
    .pop_data  (head_evt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head_evt.code;
  assign evt_press = head_evt.press;
  assign pop       = evt_valid && evt_ready;
  assign drop      = evt_push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_event.sv
// tb/tb_btn_event.sv - scoreboard bench for btn_event with a cycle-level reference model
module tb_btn_event;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [24:0] btn;
  logic        evt_valid;
  logic [4:0]  evt_code;
  logic        evt_press;
  logic        evt_ready;
  logic [24:0] key_state;
  logic        overflow;
  logic        ovf_clr;

  btn_event #(
    .DEBOUNCE_CYCLES (D),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .evt_ready (evt_ready),
    .key_state (key_state),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a key vector commits once the sampled vector has held
  // for D cycles while the decoder is idle; its changes are then pushed one
  // per cycle in ascending key order, into a FIFO of DEPTH entries.
  typedef struct {
    int         cyc;
    logic       press;
    logic [4:0] code;
  } sched_t;

  sched_t      sched[$];
  logic [5:0]  exp_q[$];
  logic [24:0] m_key;
  logic [24:0] m_samp;
  int          m_since;
  int          m_idle_from;
  int          m_occ;
  logic        m_ovf;
  bit          m_commit_pend;
  int          m_commit_cyc;
  logic [24:0] m_commit_val;
  int          cyc;
  bit          check_en;

  // Consumes the inputs applied during cycle 'cyc' and moves the model to
  // the state visible in cycle cyc+1.
  task automatic model_advance();
    int          k;
    int          n;
    bit          pop;
    bit          accepted;
    bit          ovf_set;
    logic [24:0] chg;
    sched_t      s;
    k        = cyc;
    accepted = 0;
    ovf_set  = 0;
    if (!rst_n) begin
      m_key         = '0;
      m_samp        = '0;
      m_since       = k + 1;
      m_idle_from   = k + 1;
      m_occ         = 0;
      m_ovf         = 1'b0;
      m_commit_pend = 0;
      sched.delete();
      exp_q.delete();
      return;
    end
    pop = evt_ready && (m_occ > 0);
    if (k >= m_idle_from && m_samp != m_key && (k - m_since) >= D - 1) begin
      chg = btn ^ m_key;
      n   = 0;
      for (int i = 0; i < 25; i++) begin
        if (chg[i]) begin
          s.cyc   = k + 2 + n;
          s.press = btn[i];
          s.code  = 5'(i);
          sched.push_back(s);
          n++;
        end
      end
      m_commit_pend = 1;
      m_commit_cyc  = k + 1;
      m_commit_val  = btn;
      m_idle_from   = k + 2 + ((n > 0) ? n : 1);
    end
    if (sched.size() > 0 && sched[0].cyc == k) begin
      s = sched.pop_front();
      if (m_occ == DEPTH && !pop) begin
        ovf_set = 1;
      end else begin
        exp_q.push_back({s.press, s.code});
        accepted = 1;
      end
    end
    m_occ = m_occ - (pop ? 1 : 0) + (accepted ? 1 : 0);
    if (ovf_set) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (m_commit_pend && m_commit_cyc == k) begin
      m_key         = m_commit_val;
      m_commit_pend = 0;
    end
    if (btn != m_samp) begin
      m_samp  = btn;
      m_since = k + 1;
    end
  endtask

  logic [5:0] mon_e;

  always @(negedge clk) begin
    if (check_en) begin
      check("key_state", 32'(key_state), 32'(m_key));
      check("evt_valid", 32'(evt_valid), 32'(m_occ > 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (!evt_valid) begin
        check("empty_head", 32'({evt_press, evt_code}), 32'h0);
      end else if (evt_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL evt_pop: event 0x%0h popped, none expected (t=%0t)",
                   {evt_press, evt_code}, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("evt_code", 32'(evt_code), 32'(mon_e[4:0]));
          check("evt_press", 32'(evt_press), 32'(mon_e[5]));
        end
      end
    end
  end

  task automatic step(input logic [24:0] b, input logic r, input logic c, input logic rn);
    @(posedge clk);
    #1;
    model_advance();
    cyc++;
    check_en  = 1;
    btn       = b;
    evt_ready = r;
    ovf_clr   = c;
    rst_n     = rn;
  endtask

  task automatic hold(input logic [24:0] b, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      step(b, r, 1'b0, 1'b1);
    end
  endtask

  logic [24:0] six;
  logic [24:0] four;
  logic [24:0] rb;
  int          rr;

  initial begin
    btn       = '0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    rst_n     = 1'b0;
    cyc       = 0;
    check_en  = 0;

    repeat (3) step('0, 1'b0, 1'b0, 1'b0);
    hold('0, 1'b1, 3);

    // single press then release
    hold(25'(1) << 7, 1'b1, 10);
    hold('0, 1'b1, 10);

    // glitch shorter than the debounce window
    hold(25'(1) << 3, 1'b1, 3);
    hold('0, 1'b1, 10);

    // multi-key press, then release
    hold((25'(1) << 2) | (25'(1) << 10) | (25'(1) << 24), 1'b1, 12);
    hold('0, 1'b1, 12);

    // mixed press/release in one commit
    hold((25'(1) << 1) | (25'(1) << 5), 1'b1, 10);
    hold((25'(1) << 5) | (25'(1) << 6), 1'b1, 12);
    hold('0, 1'b1, 12);

    // overflow with no consumer, clear, then full FIFO with push and pop together
    six = (25'(1) << 0) | (25'(1) << 3) | (25'(1) << 8) | (25'(1) << 9) |
          (25'(1) << 15) | (25'(1) << 20);
    hold(six, 1'b0, 14);
    step(six, 1'b0, 1'b1, 1'b1);
    hold(six, 1'b0, 2);
    four = six & ~((25'(1) << 15) | (25'(1) << 20));
    hold(four, 1'b0, 6);
    hold(four, 1'b1, 12);
    hold('0, 1'b1, 14);

    // reset in the middle of emitting a three-key commit
    hold((25'(1) << 4) | (25'(1) << 11) | (25'(1) << 17), 1'b1, 7);
    step((25'(1) << 4) | (25'(1) << 11) | (25'(1) << 17), 1'b1, 1'b0, 1'b0);
    hold((25'(1) << 4) | (25'(1) << 11) | (25'(1) << 17), 1'b1, 12);
    hold('0, 1'b1, 12);

    // randomized traffic, alternating busy and sluggish consumer phases
    rb = '0;
    for (int i = 0; i < 3000; i++) begin
      rr = int'($urandom_range(0, 99));
      if (rr < 12) rb = rb ^ (25'(1) << $urandom_range(0, 24));
      else if (rr < 14) rb = '0;
      else if (rr < 16) rb = 25'($urandom) & 25'($urandom) & 25'($urandom);
      step(rb,
           ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 599) != 0);
    end

    hold('0, 1'b1, 40);
    check("drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
